// File: rtl/pl_ifid_queue_pkg.sv
// Shared pipeline constants and small elaboration helpers.
package pl_pkg;
  localparam int WORD = 32;
  localparam logic [WORD-1:0] NOP_INST = '0;

  // Pointer width for a queue of d entries; never below one bit.
  function automatic int ptr_w(input int d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction
endpackage

// File: rtl/pl_ifid_queue_if.sv
// Fetch/decode side of the IF/ID queue: push handshake, pop strobe, head view.
interface pl_ifid_if
  import pl_pkg::*;
#(
  parameter int WIDTH = WORD,
  parameter int DEPTH = 4
) ();
  logic                   flush;
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       pc4;
  logic [WIDTH-1:0]       ins;
  logic                   wpcir;
  logic                   out_valid;
  logic [WIDTH-1:0]       dpc4;
  logic [WIDTH-1:0]       inst;
  logic [$clog2(DEPTH):0] count;

  modport master (
    output flush, in_valid, pc4, ins, wpcir,
    input  in_ready, out_valid, dpc4, inst, count
  );

  modport slave (
    input  flush, in_valid, pc4, ins, wpcir,
    output in_ready, out_valid, dpc4, inst, count
  );
endinterface

// File: rtl/pl_ifid_queue_mem.sv
// DEPTH x DW register array: synchronous write, asynchronous read, no reset.
module pl_fifo_mem
  import pl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = 2 * WORD,
  parameter int AW    = ptr_w(DEPTH)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];

  // Storage write; contents survive reset and flush on purpose.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/pl_ifid_queue.sv
// IF/ID decoupling queue: fetch pushes {pc4, ins}, decode pops on wpcir.
// Flush clears occupancy and pointers; outputs depend on registered state only.
module pl_ifid_queue
  import pl_pkg::*;
#(
  parameter int               WIDTH  = WORD,
  parameter int               DEPTH  = 4,
  parameter logic [WIDTH-1:0] BUBBLE = NOP_INST
) (
  input logic     clock,
  input logic     reset,
  pl_ifid_if.slave q
);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("pl_ifid_queue: DEPTH must be a power of two >= 2");
  end

  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      count;
  logic               push, pop;
  logic [2*WIDTH-1:0] rdata;

  // Full blocks pushes even when a pop lands in the same cycle.
  assign q.in_ready  = (count != FULL);
  assign q.out_valid = (count != '0);
  assign push = q.in_valid & q.in_ready & ~q.flush;
  assign pop  = q.wpcir & q.out_valid & ~q.flush;

  // Pointer/occupancy control: reset > flush > push/pop.
  always_ff @(posedge clock) begin
    if (reset || q.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  pl_fifo_mem #(
    .DEPTH(DEPTH),
    .DW   (2 * WIDTH),
    .AW   (PW)
  ) u_mem (
    .clock(clock),
    .we   (push & ~reset),
    .waddr(wr_ptr),
    .wdata({q.pc4, q.ins}),
    .raddr(rd_ptr),
    .rdata(rdata)
  );

  assign q.count = count;
  assign q.dpc4  = q.out_valid ? rdata[2*WIDTH-1:WIDTH] : '0;
  assign q.inst  = q.out_valid ? rdata[WIDTH-1:0]       : BUBBLE;
endmodule
